// File: rtl/sample_req_sched.sv
// Round-robin scheduler turning serializer sample accepts into generator requests.
// Optional saturating overrun counter (ovr_cnt) built only with SAMPLE_REQ_SCHED_OVR_CNT_EN.
module sample_req_sched #(
  parameter int NCH        = 2,
  parameter int MAP_OFFSET = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCH-1:0]          accepted,
  output logic                    gen_req,
  output logic [$clog2(NCH)-1:0]  gen_ch,
  input  logic                    gen_ack,
  input  logic                    gen_done,
  input  logic                    ovr_clr,
  output logic [NCH-1:0]          overrun
`ifdef SAMPLE_REQ_SCHED_OVR_CNT_EN
  , output logic [15:0]           ovr_cnt
`endif
);

  localparam int CW = $clog2(NCH);

  typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;

  state_t         state;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] set_vec;
  logic [NCH-1:0] clr_vec;
  logic [NCH-1:0] ovr_ev;
  logic [CW-1:0]  last;
  logic [CW-1:0]  pick;
  logic [CW-1:0]  cand;
  logic           pick_vld;

  // Channel k's accept requests a sample for the channel transmitting after it.
  for (genvar k = 0; k < NCH; k++) begin : g_map
    assign set_vec[(k + MAP_OFFSET) % NCH] = accepted[k];
  end

  // A same-cycle set beats the grant clear and is not an overrun.
  for (genvar j = 0; j < NCH; j++) begin : g_bit
    assign clr_vec[j] = (state == REQ) && gen_ack && (gen_ch == CW'(j));
    assign ovr_ev[j]  = set_vec[j] && pending[j] && !clr_vec[j];
  end

  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int i = 0; i < NCH; i++) begin
      cand = CW'((int'(last) + 1 + i) % NCH);
      if (!pick_vld && pending[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
      overrun <= '0;
      gen_req <= 1'b0;
      gen_ch  <= '0;
      last    <= CW'(NCH - 1);
    end else begin
      pending <= (pending & ~clr_vec) | set_vec;
      overrun <= (ovr_clr ? '0 : overrun) | ovr_ev;
      case (state)
        IDLE: if (pick_vld) begin
          gen_ch  <= pick;
          gen_req <= 1'b1;
          state   <= REQ;
        end
        REQ: if (gen_ack) begin
          gen_req <= 1'b0;
          last    <= gen_ch;
          state   <= BUSY;
        end
        BUSY: if (gen_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SAMPLE_REQ_SCHED_OVR_CNT_EN
  logic [16:0] ev_n;
  logic [16:0] cnt_sum;

  always_comb begin
    ev_n = '0;
    for (int j = 0; j < NCH; j++) ev_n = ev_n + 17'(ovr_ev[j]);
    cnt_sum = (ovr_clr ? 17'd0 : {1'b0, ovr_cnt}) + ev_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovr_cnt <= '0;
    else       ovr_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_sample_req_sched.sv
// Bench for sample_req_sched: directed handshake scenarios on NCH=2 and NCH=4 instances
// plus randomized traffic on NCH=4 checked against a queue-free behavioural model.
module tb_sample_req_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic       rst2 = 1'b1, ack2 = 1'b0, done2 = 1'b0, clr2 = 1'b0;
  logic [1:0] acc2 = '0, ovr2;
  logic       req2;
  logic [0:0] ch2;
  logic       rst4 = 1'b1, ack4 = 1'b0, done4 = 1'b0, clr4 = 1'b0;
  logic [3:0] acc4 = '0, ovr4;
  logic       req4;
  logic [1:0] ch4;
`ifdef SAMPLE_REQ_SCHED_OVR_CNT_EN
  logic [15:0] cnt2, cnt4;
`endif

  sample_req_sched #(.NCH(2), .MAP_OFFSET(1)) u_dut2 (
    .clk(clk), .reset(rst2), .accepted(acc2), .gen_req(req2), .gen_ch(ch2),
    .gen_ack(ack2), .gen_done(done2), .ovr_clr(clr2), .overrun(ovr2)
`ifdef SAMPLE_REQ_SCHED_OVR_CNT_EN
    , .ovr_cnt(cnt2)
`endif
  );

  sample_req_sched #(.NCH(4), .MAP_OFFSET(1)) u_dut4 (
    .clk(clk), .reset(rst4), .accepted(acc4), .gen_req(req4), .gen_ch(ch4),
    .gen_ack(ack4), .gen_done(done4), .ovr_clr(clr4), .overrun(ovr4)
`ifdef SAMPLE_REQ_SCHED_OVR_CNT_EN
    , .ovr_cnt(cnt4)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model of the NCH=4, MAP_OFFSET=1 instance.
  bit       m_req, m_busy;
  int       m_ch, m_last, m_cnt;
  bit [3:0] m_pend, m_ovr;

  task automatic model_reset;
    m_req = 0; m_busy = 0; m_ch = 0; m_last = 3; m_cnt = 0; m_pend = '0; m_ovr = '0;
  endtask

  task automatic model_step(input bit [3:0] acc, input bit ack, input bit done, input bit clr);
    int       granted, ev, t;
    bit [3:0] ev_bits, nxt;
    granted = (m_req && ack) ? m_ch : -1;
    ev = 0; ev_bits = '0; nxt = m_pend;
    if (granted >= 0) nxt[granted] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (acc[k]) begin
        t = (k + 1) % 4;
        if (m_pend[t] && t != granted) begin ev++; ev_bits[t] = 1'b1; end
        nxt[t] = 1'b1;
      end
    end
    m_ovr = clr ? ev_bits : (m_ovr | ev_bits);
    m_cnt = (clr ? 0 : m_cnt) + ev;
    if (m_cnt > 65535) m_cnt = 65535;
    if (m_req) begin
      if (ack) begin m_req = 0; m_busy = 1; m_last = m_ch; end
    end else if (m_busy) begin
      if (done) m_busy = 0;
    end else if (m_pend != 0) begin
      for (int i = 1; i <= 4; i++) begin
        t = (m_last + i) % 4;
        if (m_pend[t]) begin m_ch = t; m_req = 1; break; end
      end
    end
    m_pend = nxt;
  endtask

  task automatic test_reset;
    rst2 = 1'b1; rst4 = 1'b1;
    tick;
    rst2 = 1'b0; rst4 = 1'b0;
    n_tests++; if (req2 !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", req2); end
    n_tests++; if (ch2 !== 1'b0) begin n_fail++; $display("FAIL reset_ch: got %b want 0", ch2); end
    n_tests++; if (ovr2 !== 2'b00) begin n_fail++; $display("FAIL reset_ovr: got %b want 00", ovr2); end
    n_tests++; if (ovr4 !== 4'b0000 || req4 !== 1'b0) begin n_fail++; $display("FAIL reset_dut4: ovr %b req %b want 0", ovr4, req4); end
`ifdef SAMPLE_REQ_SCHED_OVR_CNT_EN
    n_tests++; if (cnt2 !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", cnt2); end
`endif
    tick;
    n_tests++; if (req2 !== 1'b0) begin n_fail++; $display("FAIL reset_idle_req: got %b want 0", req2); end
  endtask

  task automatic test_latency;
    acc2 = 2'b01; tick; acc2 = 2'b00;
    n_tests++; if (req2 !== 1'b0) begin n_fail++; $display("FAIL lat_early: got %b want 0", req2); end
    tick;
    n_tests++; if (req2 !== 1'b1 || ch2 !== 1'b1) begin n_fail++; $display("FAIL lat_grant: req %b ch %b want 1/1", req2, ch2); end
    done2 = 1'b1; tick; done2 = 1'b0; tick;
    n_tests++; if (req2 !== 1'b1 || ch2 !== 1'b1) begin n_fail++; $display("FAIL lat_hold: req %b ch %b want 1/1", req2, ch2); end
    ack2 = 1'b1; tick; ack2 = 1'b0;
    n_tests++; if (req2 !== 1'b0) begin n_fail++; $display("FAIL lat_ack: got %b want 0", req2); end
    tick; tick; done2 = 1'b1; tick; done2 = 1'b0; tick; tick;
    n_tests++; if (req2 !== 1'b0 || ovr2 !== 2'b00) begin n_fail++; $display("FAIL lat_idle: req %b ovr %b want 0/00", req2, ovr2); end
  endtask

  task automatic test_overrun;
    acc2 = 2'b01; tick; acc2 = 2'b00;
    repeat (9) tick;
    acc2 = 2'b01; tick; acc2 = 2'b00;
    n_tests++; if (ovr2 !== 2'b10) begin n_fail++; $display("FAIL ovr_flag: got %b want 10", ovr2); end
    n_tests++; if (req2 !== 1'b1 || ch2 !== 1'b1) begin n_fail++; $display("FAIL ovr_grant: req %b ch %b want 1/1", req2, ch2); end
`ifdef SAMPLE_REQ_SCHED_OVR_CNT_EN
    n_tests++; if (cnt2 !== 16'd1) begin n_fail++; $display("FAIL ovr_cnt: got %0d want 1", cnt2); end
`endif
    clr2 = 1'b1; tick; clr2 = 1'b0;
    n_tests++; if (ovr2 !== 2'b00) begin n_fail++; $display("FAIL ovr_clr: got %b want 00", ovr2); end
`ifdef SAMPLE_REQ_SCHED_OVR_CNT_EN
    n_tests++; if (cnt2 !== 16'd0) begin n_fail++; $display("FAIL ovr_clr_cnt: got %0d want 0", cnt2); end
`endif
    ack2 = 1'b1; tick; ack2 = 1'b0; done2 = 1'b1; tick; done2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      n_tests++; if (req2 !== 1'b0) begin n_fail++; $display("FAIL ovr_single_grant: cyc %0d req %b want 0", i, req2); end
    end
  endtask

  task automatic test_same_cycle;
    acc2 = 2'b01; tick; acc2 = 2'b00; tick;
    n_tests++; if (req2 !== 1'b1 || ch2 !== 1'b1) begin n_fail++; $display("FAIL same_grant: req %b ch %b want 1/1", req2, ch2); end
    ack2 = 1'b1; acc2 = 2'b01; tick; ack2 = 1'b0; acc2 = 2'b00;
    n_tests++; if (req2 !== 1'b0 || ovr2 !== 2'b00) begin n_fail++; $display("FAIL same_no_ovr: req %b ovr %b want 0/00", req2, ovr2); end
    tick; done2 = 1'b1; tick; done2 = 1'b0; tick;
    n_tests++; if (req2 !== 1'b1 || ch2 !== 1'b1) begin n_fail++; $display("FAIL same_regrant: req %b ch %b want 1/1", req2, ch2); end
    ack2 = 1'b1; tick; ack2 = 1'b0; done2 = 1'b1; tick; done2 = 1'b0; tick;
  endtask

  task automatic test_reset_mid;
    rst2 = 1'b1; tick; rst2 = 1'b0;
    acc2 = 2'b11; tick; acc2 = 2'b00; tick;
    n_tests++; if (req2 !== 1'b1 || ch2 !== 1'b0) begin n_fail++; $display("FAIL rst_first_ch: req %b ch %b want 1/0", req2, ch2); end
    ack2 = 1'b1; tick; ack2 = 1'b0;
    acc2 = 2'b10; tick; tick; acc2 = 2'b00;
    n_tests++; if (ovr2 !== 2'b01 || req2 !== 1'b0) begin n_fail++; $display("FAIL rst_setup: ovr %b req %b want 01/0", ovr2, req2); end
    #2 rst2 = 1'b1;
    #1;
    n_tests++; if (req2 !== 1'b0 || ch2 !== 1'b0 || ovr2 !== 2'b00) begin n_fail++; $display("FAIL rst_async: req %b ch %b ovr %b want 0/0/00", req2, ch2, ovr2); end
`ifdef SAMPLE_REQ_SCHED_OVR_CNT_EN
    n_tests++; if (cnt2 !== 16'd0) begin n_fail++; $display("FAIL rst_async_cnt: got %0d want 0", cnt2); end
`endif
    tick; rst2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      n_tests++; if (req2 !== 1'b0) begin n_fail++; $display("FAIL rst_dropped: cyc %0d req %b want 0", i, req2); end
    end
    acc2 = 2'b01; tick; acc2 = 2'b00; tick;
    n_tests++; if (req2 !== 1'b1 || ch2 !== 1'b1) begin n_fail++; $display("FAIL rst_new_grant: req %b ch %b want 1/1", req2, ch2); end
    rst2 = 1'b1; tick; rst2 = 1'b0;
  endtask

  task automatic test_rr4;
    int g, last_c;
    g = 0; last_c = -100;
    rst4 = 1'b1; tick; rst4 = 1'b0;
    acc4 = 4'b1111; tick; acc4 = 4'b0000;
    for (int c = 0; c < 40; c++) begin
      tick;
      done4 = ack4; ack4 = 1'b0;
      if (req4) begin
        n_tests++;
        if (int'(ch4) !== g || (g > 0 && c - last_c != 3)) begin
          n_fail++; $display("FAIL rr4_grant: ch %0d gap %0d want ch %0d gap 3", ch4, c - last_c, g);
        end
        g++; last_c = c; ack4 = 1'b1;
      end
    end
    done4 = 1'b0;
    n_tests++; if (g !== 4) begin n_fail++; $display("FAIL rr4_count: got %0d grants want 4", g); end
    n_tests++; if (ovr4 !== 4'b0000) begin n_fail++; $display("FAIL rr4_ovr: got %b want 0000", ovr4); end
  endtask

  task automatic test_random;
    rst4 = 1'b1; model_reset; tick; rst4 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      acc4  = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      ack4  = ($urandom_range(0, 2) == 0);
      done4 = ($urandom_range(0, 2) == 0);
      clr4  = ($urandom_range(0, 49) == 0);
      model_step(acc4, ack4, done4, clr4);
      tick;
      n_tests++;
      if (req4 !== m_req || (m_req && int'(ch4) !== m_ch) || ovr4 !== m_ovr) begin
        n_fail++; $display("FAIL rand_cyc%0d: req %b ch %0d ovr %b want %b %0d %b", c, req4, ch4, ovr4, m_req, m_ch, m_ovr);
      end
`ifdef SAMPLE_REQ_SCHED_OVR_CNT_EN
      n_tests++; if (int'(cnt4) !== m_cnt) begin n_fail++; $display("FAIL rand_cnt%0d: got %0d want %0d", c, cnt4, m_cnt); end
`endif
    end
    acc4 = '0; ack4 = 1'b0; done4 = 1'b0; clr4 = 1'b0;
  endtask

`ifdef SAMPLE_REQ_SCHED_OVR_CNT_EN
  task automatic test_saturate;
    rst4 = 1'b1; tick; rst4 = 1'b0;
    acc4 = 4'b1111;
    repeat (10) tick;
    n_tests++; if (cnt4 !== 16'd36) begin n_fail++; $display("FAIL sat_ramp: got %0d want 36", cnt4); end
    repeat (16400) tick;
    n_tests++; if (cnt4 !== 16'hFFFF || ovr4 !== 4'b1111) begin n_fail++; $display("FAIL sat_cnt: cnt %h ovr %b want ffff/1111", cnt4, ovr4); end
    acc4 = 4'b0000;
    rst4 = 1'b1; tick; rst4 = 1'b0;
  endtask
`endif

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_latency;
    test_overrun;
    test_same_cycle;
    test_reset_mid;
    test_rr4;
    test_random;
`ifdef SAMPLE_REQ_SCHED_OVR_CNT_EN
    test_saturate;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
